mc_controller: RTL

//  Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes per state.

---
 rtl/mc_controller.sv | 98 +++++++++
 1 files changed

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM with mem_ready handshake, watchdog and illegal-op detection
module mc_controller #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W = 4,
  parameter bit SUBWORD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_flag,
  output logic        ir_write,
  output logic        pc_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  reg_src,
  output logic        alu_src,
  output logic [4:0]  alu_ctrl,
  output logic [2:0]  ext_ctrl,
  output logic [2:0]  npc_ctrl,
  output logic [2:0]  dm_ctrl,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout_err
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
  state_t cur, nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [5:0] op, fn;
  logic r, r_alu, jr, jalr, ori, lui, addi, lb, lh, sb, sh, load, store, br, j, jal, wb_path, legal;
  logic waiting, expired, unused_bits;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_bits = ^instr[25:6];
  assign r = op == 6'h00;
  assign r_alu = r && (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h00});
  assign jr = r && fn == 6'h08;
  assign jalr = r && fn == 6'h09;
  assign ori = op == 6'h0d;
  assign lui = op == 6'h0f;
  assign addi = op inside {6'h08, 6'h09};
  assign lb = SUBWORD_EN && op == 6'h20;
  assign lh = SUBWORD_EN && op == 6'h21;
  assign sb = SUBWORD_EN && op == 6'h28;
  assign sh = SUBWORD_EN && op == 6'h29;
  assign load = op == 6'h23 || lb || lh;
  assign store = op == 6'h2b || sb || sh;
  assign br = op inside {6'h04, 6'h05};
  assign j = op == 6'h02;
  assign jal = op == 6'h03;
  assign wb_path = r_alu || ori || lui || addi || jal || jalr;
  assign legal = wb_path || load || store || br || j || jr;
  // ALU encoding: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll, 6 pass extended imm (lui)
  assign reg_dst = r ? 2'b01 : jal ? 2'b10 : 2'b00;
  assign reg_src = load ? 2'b01 : (jal || jalr) ? 2'b10 : 2'b00;
  assign alu_src = ori || lui || addi || load || store;
  assign alu_ctrl = (br || (r && fn == 6'h23)) ? 5'd1 : (r && fn == 6'h24) ? 5'd2 :
                    (ori || (r && fn == 6'h25)) ? 5'd3 : (r && fn == 6'h2a) ? 5'd4 :
                    (r && fn == 6'h00) ? 5'd5 : lui ? 5'd6 : 5'd0;
  assign ext_ctrl = lui ? 3'b010 : br ? 3'b011 : (addi || load || store) ? 3'b001 : 3'b000;
  assign npc_ctrl = br ? {2'b00, alu_flag} : (j || jal) ? 3'b010 : (jr || jalr) ? 3'b011 : 3'b000;
  assign dm_ctrl = cur == FETCH ? 3'b000 : (lh || sh) ? 3'b001 : (lb || sb) ? 3'b010 : 3'b000;
  assign state = cur;
  assign timeout_err = cur == HALT;
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= FETCH;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      wait_cnt <= wait_nxt;
    end
  end
  always_comb begin
    nxt = cur;
    waiting = (cur == FETCH || cur == MEM) && !mem_ready;
    expired = waiting && wait_cnt == WAIT_W'(MAX_WAIT - 1);
    wait_nxt = waiting ? wait_cnt + 1'b1 : '0;
    case (cur)
      FETCH:   nxt = mem_ready ? DECODE : expired ? HALT : FETCH;
      DECODE:  nxt = legal ? EXEC : FETCH;
      EXEC:    nxt = wb_path ? WB : (load || store) ? MEM : FETCH;
      MEM:     nxt = mem_ready ? (load ? WB : FETCH) : expired ? HALT : MEM;
      WB:      nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
    ir_write = !reset && cur == FETCH && mem_ready;
    mem_read = !reset && (cur == FETCH || (cur == MEM && load));
    mem_write = !reset && cur == MEM && store;
    reg_write = !reset && cur == WB;
    illegal = !reset && cur == DECODE && !legal;
    pc_write = !reset && ((cur == DECODE && !legal) || (cur == EXEC && (br || j || jr)) ||
               (cur == MEM && store && mem_ready) || cur == WB);
  end
endmodule
